// File: rtl/axi_rd_resp_gen.sv
// AXI read-response generator: stores AR requests and returns synthetic R bursts in a selectable order.
// Optional macro AXI_RD_RESP_GEN_ERR_INJECT_EN: requests with the top address bit set return SLVERR.
module axi_rd_resp_gen #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ar_valid,
   output logic                           ar_ready,
   input  logic [ID_WIDTH-1:0]            ar_id,
   input  logic [ADDR_WIDTH-1:0]          ar_addr,
   input  logic [LEN_WIDTH-1:0]           ar_len,
   input  logic [1:0]                     order_mode,
   output logic                           r_valid,
   input  logic                           r_ready,
   output logic [ID_WIDTH-1:0]            r_id,
   output logic [DATA_WIDTH-1:0]          r_data,
   output logic [1:0]                     r_resp,
   output logic                           r_last,
   output logic [$clog2(DEPTH+1)-1:0]     outstanding
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned SEQ_W = IDX_W + 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_BURST} state_t;

   state_t                 r_state, w_state_nxt;
   logic [DEPTH-1:0]       r_vld;
   logic [ID_WIDTH-1:0]    r_tid   [DEPTH];
   logic [ADDR_WIDTH-1:0]  r_taddr [DEPTH];
   logic [LEN_WIDTH-1:0]   r_tlen  [DEPTH];
   logic [SEQ_W-1:0]       r_tseq  [DEPTH];
   logic [SEQ_W-1:0]       r_seq_cnt;
   logic [CNT_W-1:0]       r_count;
   logic [7:0]             r_lfsr;
   logic                   r_ar_ready;
   logic [IDX_W-1:0]       r_sel;
   logic [LEN_WIDTH-1:0]   r_beat;
   logic                   r_out_valid;
   logic [ID_WIDTH-1:0]    r_out_id;
   logic [DATA_WIDTH-1:0]  r_out_data;
   logic [1:0]             r_out_resp;
   logic                   r_out_last;

   logic [IDX_W-1:0]       w_free_idx;
   logic                   w_free_found;
   logic                   w_accept;
   logic                   w_release;
   logic [CNT_W-1:0]       w_count_nxt;
   logic [1:0]             w_mode_eff;
   logic [IDX_W-1:0]       w_pick;
   logic                   w_pick_found;
   logic [SEQ_W-1:0]       w_best_age;
   logic [IDX_W-1:0]       w_start;
   logic [IDX_W-1:0]       w_sel_nxt;
   logic [LEN_WIDTH-1:0]   w_beat_nxt;
   logic                   w_out_valid;
   logic [ID_WIDTH-1:0]    w_out_id;
   logic [DATA_WIDTH-1:0]  w_out_data;
   logic [1:0]             w_out_resp;
   logic                   w_out_last;

   function automatic logic [DATA_WIDTH-1:0] f_beat_data(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [LEN_WIDTH-1:0]  b);
      f_beat_data = (DATA_WIDTH'(a) << 16) | DATA_WIDTH'(16'(b));
   endfunction

   assign ar_ready    = r_ar_ready;
   assign outstanding = r_count;
   assign r_valid     = r_out_valid;
   assign r_id        = r_out_id;
   assign r_data      = r_out_data;
   assign r_resp      = r_out_resp;
   assign r_last      = r_out_last;

   // Lowest free slot; an entry being released this cycle still reads as valid.
   always_comb begin
      w_free_idx   = '0;
      w_free_found = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!w_free_found && !r_vld[i]) begin
            w_free_idx   = IDX_W'(i);
            w_free_found = 1'b1;
         end
      end
   end

   assign w_accept    = ar_valid && r_ar_ready && w_free_found;
   assign w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_release);
   assign w_mode_eff  = (order_mode == 2'd3) ? 2'd0 : order_mode;
   assign w_start     = r_lfsr[IDX_W-1:0];

   // Entry pick: age is measured back from the sequence counter so wrap-around is harmless.
   always_comb begin
      w_pick       = '0;
      w_pick_found = 1'b0;
      w_best_age   = '0;
      if (w_mode_eff == 2'd2) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            if (!w_pick_found && r_vld[w_start + IDX_W'(k)]) begin
               w_pick       = w_start + IDX_W'(k);
               w_pick_found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_vld[i] && (!w_pick_found ||
                ((w_mode_eff == 2'd0) ? (SEQ_W'(r_seq_cnt - r_tseq[i]) > w_best_age)
                                      : (SEQ_W'(r_seq_cnt - r_tseq[i]) < w_best_age)))) begin
               w_pick       = IDX_W'(i);
               w_pick_found = 1'b1;
               w_best_age   = SEQ_W'(r_seq_cnt - r_tseq[i]);
            end
         end
      end
   end

   // Next state and next registered R-channel values.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_beat_nxt  = r_beat;
      w_release   = 1'b0;
      w_out_valid = r_out_valid;
      w_out_id    = r_out_id;
      w_out_data  = r_out_data;
      w_out_resp  = r_out_resp;
      w_out_last  = r_out_last;
      case (r_state)
         S_IDLE: begin
            if (|r_vld) w_state_nxt = S_SELECT;
         end
         S_SELECT: begin
            w_state_nxt = S_BURST;
            w_sel_nxt   = w_pick;
            w_beat_nxt  = '0;
            w_out_valid = 1'b1;
            w_out_id    = r_tid[w_pick];
            w_out_data  = f_beat_data(r_taddr[w_pick], '0);
            w_out_last  = (r_tlen[w_pick] == '0);
`ifdef AXI_RD_RESP_GEN_ERR_INJECT_EN
            w_out_resp  = r_taddr[w_pick][ADDR_WIDTH-1] ? 2'b10 : 2'b00;
`else
            w_out_resp  = 2'b00;
`endif
         end
         S_BURST: begin
            if (r_out_valid && r_ready) begin
               if (r_out_last) begin
                  w_state_nxt = S_IDLE;
                  w_release   = 1'b1;
                  w_out_valid = 1'b0;
                  w_out_id    = '0;
                  w_out_data  = '0;
                  w_out_resp  = 2'b00;
                  w_out_last  = 1'b0;
               end else begin
                  w_beat_nxt  = r_beat + LEN_WIDTH'(1);
                  w_out_data  = f_beat_data(r_taddr[r_sel], w_beat_nxt);
                  w_out_last  = (w_beat_nxt == r_tlen[r_sel]);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Table bookkeeping, outstanding count, LFSR (x^8+x^6+x^5+x^4+1).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld      <= '0;
         r_count    <= '0;
         r_seq_cnt  <= '0;
         r_lfsr     <= 8'hA5;
         r_ar_ready <= 1'b1;
      end else begin
         r_lfsr     <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         r_count    <= w_count_nxt;
         r_ar_ready <= (w_count_nxt < CNT_W'(DEPTH));
         if (w_release) r_vld[r_sel] <= 1'b0;
         if (w_accept) begin
            r_vld[w_free_idx] <= 1'b1;
            r_seq_cnt         <= r_seq_cnt + SEQ_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tid[w_free_idx]   <= ar_id;
         r_taddr[w_free_idx] <= ar_addr;
         r_tlen[w_free_idx]  <= ar_len;
         r_tseq[w_free_idx]  <= r_seq_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel       <= '0;
         r_beat      <= '0;
         r_out_valid <= 1'b0;
         r_out_id    <= '0;
         r_out_data  <= '0;
         r_out_resp  <= 2'b00;
         r_out_last  <= 1'b0;
      end else begin
         r_sel       <= w_sel_nxt;
         r_beat      <= w_beat_nxt;
         r_out_valid <= w_out_valid;
         r_out_id    <= w_out_id;
         r_out_data  <= w_out_data;
         r_out_resp  <= w_out_resp;
         r_out_last  <= w_out_last;
      end
   end

endmodule

// File: tb/tb_axi_rd_resp_gen.sv
// Directed bench for axi_rd_resp_gen with an expected-beat scoreboard and stall-stability monitor.
module tb_axi_rd_resp_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        ar_valid;
   logic        ar_ready;
   logic [3:0]  ar_id;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [1:0]  order_mode;
   logic        r_valid;
   logic        r_ready;
   logic [3:0]  r_id;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic [3:0]  outstanding;

   always #5 clk = ~clk;

   axi_rd_resp_gen dut (
      .clk(clk), .rst(rst),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
      .order_mode(order_mode),
      .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
      .r_last(r_last), .outstanding(outstanding)
   );

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    n_assert = 0;
   int    n_fail   = 0;
   bit    unordered = 1'b0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] f_data(input logic [31:0] a, input int i);
      return ({32'h0, a} << 16) | 64'(i[15:0]);
   endfunction

   function automatic logic [1:0] f_resp(input logic [31:0] a);
`ifdef AXI_RD_RESP_GEN_ERR_INJECT_EN
      return a[31] ? 2'b10 : 2'b00;
`else
      return (a == 32'hFFFF_FFFF) ? 2'b00 : 2'b00;
`endif
   endfunction

   task automatic push_exp(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
      beat_t b;
      for (int i = 0; i <= int'(len); i++) begin
         b.id   = id;
         b.data = f_data(a, i);
         b.resp = f_resp(a);
         b.last = (i == int'(len));
         sb.push_back(b);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input bit push);
      int cnt;
      ar_valid = 1'b1; ar_id = id; ar_addr = a; ar_len = len;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (ar_ready) break;
         cnt++;
         if (cnt > 200) begin
            check("ar_timeout", ar_ready, 1);
            break;
         end
      end
      @(posedge clk);
      #1 ar_valid = 1'b0;
      if (push) push_exp(id, a, len);
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 400) begin
         @(posedge clk);
         k++;
      end
      tick(3);
      check({tag, "_drain"}, sb.size(), 0);
   endtask

   // R-channel monitor: scoreboard compare on handshake, hold check across stalls.
   logic  p_v, p_rdy;
   beat_t p_b;
   always @(negedge clk) begin
      beat_t cur;
      int    idx;
      bit    have;
      cur = {r_id, r_data, r_resp, r_last};
      if (rst) begin
         p_v = 1'b0;
      end else begin
         if (p_v && !p_rdy) check("stall_hold", {r_valid, cur}, {1'b1, p_b});
         if (r_valid && r_ready) begin
            if (unordered) begin
               idx = -1;
               foreach (sb[j]) if (idx < 0 && sb[j].data == cur.data) idx = j;
               check("beat_known", idx >= 0, 1);
               if (idx >= 0) begin
                  check("beat_unordered", cur, sb[idx]);
                  sb.delete(idx);
               end
            end else begin
               have = (sb.size() > 0);
               check("beat_expected", have, 1);
               if (have) check("beat", cur, sb.pop_front());
            end
         end
         p_v   = r_valid;
         p_rdy = r_ready;
         p_b   = cur;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw;
      bit ok;
      rst = 1'b1; ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0;
      order_mode = 2'd0; r_ready = 1'b1;
      tick(3);
      check("reset_outputs", {r_valid, r_last, r_resp, r_id, r_data}, 0);
      rst = 1'b0;
      tick(1);
      check("reset_ar_ready", ar_ready, 1);
      check("reset_outstanding", outstanding, 0);

      // Single beat and first-response latency
      issue(4'd0, 32'h1000, 8'd0, 1'b1);
      check("lat_outstanding", outstanding, 1);
      check("lat_c0", r_valid, 0);
      tick(1);
      check("lat_c1", r_valid, 0);
      tick(1);
      check("lat_c2", r_valid, 1);
      check("single_data", r_data, 64'h0000_0000_1000_0000);
      drain("single");

      // Oldest-first
      issue(4'd3, 32'h2000, 8'd0, 1'b1);
      issue(4'd3, 32'h3000, 8'd0, 1'b1);
      drain("mode0");

      // Newest-first, both pending while a blocker burst is stalled
      order_mode = 2'd1; r_ready = 1'b0;
      issue(4'd1, 32'h5000, 8'd0, 1'b1);
      tick(3);
      issue(4'd3, 32'h2000, 8'd0, 1'b0);
      issue(4'd3, 32'h3000, 8'd0, 1'b0);
      push_exp(4'd3, 32'h3000, 8'd0);
      push_exp(4'd3, 32'h2000, 8'd0);
      r_ready = 1'b1;
      drain("mode1");

      // Mode 3 behaves as oldest-first
      order_mode = 2'd3; r_ready = 1'b0;
      issue(4'd2, 32'h0C000, 8'd0, 1'b1);
      tick(3);
      issue(4'd6, 32'h0C100, 8'd1, 1'b1);
      issue(4'd7, 32'h0C200, 8'd0, 1'b1);
      r_ready = 1'b1;
      drain("mode3");
      order_mode = 2'd0;

      // Multi-beat burst with r_ready toggling
      issue(4'd5, 32'h4000, 8'd3, 1'b1);
      for (int k = 0; k < 60 && sb.size() != 0; k++) begin
         @(posedge clk);
         #1 r_ready = ~r_ready;
      end
      r_ready = 1'b1;
      drain("toggle");

      // Fill to DEPTH, then release one
      r_ready = 1'b0;
      for (int k = 0; k < 8; k++) issue(4'(k), 32'h6000 + 32'(k) * 32'h100, 8'd0, 1'b1);
      tick(1);
      check("full_outstanding", outstanding, 8);
      check("full_ar_ready", ar_ready, 0);
      ar_valid = 1'b1; ar_id = 4'd9; ar_addr = 32'h7000; ar_len = 8'd0;
      tick(4);
      check("full_no_accept", {ar_ready, outstanding}, {1'b0, 4'd8});
      r_ready = 1'b1;
      saw = 1'b0; ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (saw) begin
            check("ar_ready_after_release", ar_ready, 1);
            ok = 1'b1;
            break;
         end
         if (r_valid) begin
            check("ar_ready_before_release", ar_ready, 0);
            saw = 1'b1;
         end
      end
      check("release_seen", ok, 1);
      @(posedge clk);
      #1 ar_valid = 1'b0;
      check("accept_after_release", outstanding, 8);
      push_exp(4'd9, 32'h7000, 8'd0);
      drain("full");
      check("full_empty", outstanding, 0);

      // Simultaneous accept and release
      r_ready = 1'b0;
      issue(4'd1, 32'hE000, 8'd0, 1'b1);
      issue(4'd2, 32'hE100, 8'd0, 1'b1);
      tick(3);
      ar_valid = 1'b1; ar_id = 4'd3; ar_addr = 32'hE200; ar_len = 8'd0; r_ready = 1'b1;
      @(negedge clk);
      check("simul_both", {ar_ready, r_valid}, 2'b11);
      @(posedge clk);
      #1 ar_valid = 1'b0;
      push_exp(4'd3, 32'hE200, 8'd0);
      check("simul_outstanding", outstanding, 2);
      drain("simul");

      // Pseudo-random order: set match only
      order_mode = 2'd2; unordered = 1'b1; r_ready = 1'b0;
      issue(4'd4, 32'hD000, 8'd1, 1'b1);
      issue(4'd5, 32'hD100, 8'd0, 1'b1);
      issue(4'd6, 32'hD200, 8'd2, 1'b1);
      r_ready = 1'b1;
      drain("mode2");
      unordered = 1'b0; order_mode = 2'd0;

      // Response field, error address
      issue(4'd1, 32'h8000_0000, 8'd1, 1'b1);
      issue(4'd1, 32'h1000, 8'd0, 1'b1);
      drain("resp");

      // Reset mid-burst discards everything
      r_ready = 1'b0;
      issue(4'd2, 32'hB000, 8'd3, 1'b0);
      issue(4'd3, 32'hB100, 8'd0, 1'b0);
      tick(3);
      check("pre_reset_valid", r_valid, 1);
      rst = 1'b1;
      tick(2);
      check("midrst_outputs", {r_valid, r_last, r_resp, r_id, r_data}, 0);
      rst = 1'b0;
      sb.delete();
      r_ready = 1'b1;
      tick(10);
      check("post_rst_state", {r_valid, ar_ready, outstanding}, {1'b0, 1'b1, 4'd0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_rd_resp_gen.md
AXI_RD_RESP_GEN -- requirements
Module: axi_rd_resp_gen

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AR address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, R data width; must be >= ADDR_WIDTH+16.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, AR len width.
REQ-005 SHALL have parameter DEPTH, default 8, number of outstanding requests; power of 2, >= 2.
REQ-006 SHALL have ports (clk, rst first), all sampled and driven on posedge clk:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- ar_valid  in  1  request valid
- ar_ready  out  1  request accepted when high with ar_valid
- ar_id  in  ID_WIDTH  request ID
- ar_addr  in  ADDR_WIDTH  start address
- ar_len  in  LEN_WIDTH  beats minus 1
- order_mode  in  2  0 oldest-first, 1 newest-first, 2 pseudo-random, 3 treated as 0
- r_valid  out  1  beat valid
- r_ready  in  1  beat consumed when high with r_valid
- r_id  out  ID_WIDTH  ID of stored request
- r_data  out  DATA_WIDTH  beat data
- r_resp  out  2  beat response
- r_last  out  1  final beat of burst
- outstanding  out  clog2(DEPTH+1)  stored request count

Function
REQ-007 SHALL store accepted requests (id, addr, len) in a DEPTH-entry table with per-entry valid bit and arrival sequence number.
REQ-008 SHALL drive ar_ready = (outstanding < DEPTH), derived from registered count only; a slot freed in a cycle raises ar_ready the following cycle.
REQ-009 SHALL implement states IDLE, SELECT, BURST: IDLE->SELECT when any entry valid; SELECT->BURST after one cycle; BURST->IDLE on handshake of last beat.
REQ-010 SHALL sample order_mode only in SELECT; mode changes during BURST have no effect on the current burst.
REQ-011 Mode 0 SHALL select the valid entry with the smallest arrival sequence; mode 1 the largest.
REQ-012 Mode 2 SHALL select the first valid entry at or after index (lfsr mod DEPTH), searching upward with wrap-around; lfsr is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advanced every cycle.
REQ-013 SHALL emit ar_len+1 beats for the selected entry, consecutively, never interleaved with another entry.
REQ-014 Beat i data SHALL be (zero-extended ar_addr << 16) | i[15:0].
REQ-015 r_last SHALL be 1 only on beat ar_len; ar_len=0 gives a single beat with r_last=1.
REQ-016 r_valid SHALL be 1 only in BURST; r_id/r_data/r_resp/r_last SHALL hold stable while r_valid=1 and r_ready=0.
REQ-017 Handshake of last beat SHALL clear the entry's valid bit and decrement outstanding in the same edge.
REQ-018 Simultaneous AR accept and entry release SHALL both take effect; outstanding unchanged; new entry uses a free slot other than the released one.
REQ-019 First request into an empty block SHALL produce r_valid no earlier than 2 cycles after the AR handshake edge (IDLE->SELECT->BURST).
REQ-020 Arrival sequence counter SHALL be wide enough (clog2(DEPTH)+1 bits) that wrap-around comparisons stay correct with at most DEPTH entries live.

Reset
REQ-021 rst SHALL clear all valid bits, outstanding=0, state=IDLE, lfsr=8'hA5, sequence counter=0.
REQ-022 During and after reset: ar_ready=1 (from the cycle after rst deasserts), r_valid=0, r_last=0, r_resp=0, r_id=0, r_data=0.
REQ-023 rst asserted mid-burst SHALL abort the burst and discard all stored requests; no further beats for them.

Configuration
REQ-024 Macro AXI_RD_RESP_GEN_ERR_INJECT_EN: when defined, requests with ar_addr[ADDR_WIDTH-1]=1 SHALL return r_resp=2'b10 (SLVERR) on every beat; when undefined, r_resp SHALL always be 2'b00.

Verification
REQ-025 Single read id=0 addr=0x1000 len=0, mode 0 -> one beat id=0 data=0x0000_0000_1000_0000 last=1 resp=0.
REQ-026 Mode 0, reads id=3 addr 0x2000 then 0x3000 len=0 -> beats returned in order 0x2000_0000 then 0x3000_0000.
REQ-027 Mode 1, same two reads issued before first beat -> 0x3000 beat first, then 0x2000.
REQ-028 id=5 addr=0x4000 len=3, r_ready toggled 1/0 each cycle -> 4 beats data 0x4000_0000..0x4000_0003, last only on 4th, outputs stable during stalls.
REQ-029 Issue DEPTH+1 requests with r_ready=0 -> ar_ready=0 after DEPTH accepts, outstanding=DEPTH; raise r_ready -> 9th accepted cycle after first release.
REQ-030 With AXI_RD_RESP_GEN_ERR_INJECT_EN defined, addr=0x8000_0000 len=1 -> 2 beats resp=2'b10; addr=0x1000 -> resp=2'b00.
